// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write arbiter.
// Used by fifo_wr_arbiter and its rr_picker sub-module.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int STAT_W = 16;

  // Beat counter must hold values 0..MAX_BURST.
  function automatic int beat_cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req bit at or after rr_ptr,
// wrapping around; returns a one-hot winner and a valid flag.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  // Two passes keep every index a loop constant: first the indices at or
  // above rr_ptr, then the wrapped-around ones below it.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid && req[i] && (PTR_W'(i) >= rr_ptr)) begin
        winner[i] = 1'b1;
        valid     = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid && req[i] && (PTR_W'(i) < rr_ptr)) begin
        winner[i] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a FIFO write port, with bounded bursts.
// Optional statistics outputs are enabled by defining FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_BITS  = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                         w_clk,
  input  logic                         w_rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*NUM_BITS-1:0]  req_data,
  input  logic                         full,
  output logic [NUM_REQ-1:0]           gnt,
  output logic                         w_en,
  output logic [NUM_BITS-1:0]          w_data,
  output logic                         busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]    beat_total,
  output logic [STAT_W-1:0]            stall_cnt
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = beat_cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

  arb_state_t           state;
  arb_state_t           state_nxt;
  logic [NUM_REQ-1:0]   gnt_nxt;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     rr_ptr_nxt;
  logic [CNT_W-1:0]     beat_cnt;
  logic [CNT_W-1:0]     beat_cnt_nxt;

  logic [PTR_W-1:0]     owner;
  logic                 owner_req;
  logic                 accept;
  logic                 release_now;
  logic [PTR_W-1:0]     wrap_ptr;
  logic [NUM_REQ-1:0]   pick_req;
  logic [PTR_W-1:0]     pick_ptr;
  logic [NUM_REQ-1:0]   pick_winner;
  logic                 pick_valid;

  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) owner = PTR_W'(i);
    end
  end

  // Reset gating on accept keeps a burst from writing in the cycle it is aborted.
  assign owner_req   = |(req & gnt);
  assign accept      = (state == GRANT) && owner_req && !full && !w_rst;
  assign release_now = (state == GRANT) &&
                       (!owner_req || (accept && (beat_cnt == LAST_BEAT)));
  assign wrap_ptr    = (owner == LAST_IDX) ? '0 : owner + PTR_W'(1);

  // On release the owner is masked out, so it only wins again via IDLE.
  assign pick_req = (state == GRANT) ? (req & ~gnt) : req;
  assign pick_ptr = (state == GRANT) ? wrap_ptr : rr_ptr;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_picker (
    .req     (pick_req),
    .rr_ptr  (pick_ptr),
    .winner  (pick_winner),
    .valid   (pick_valid)
  );

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state    <= IDLE;
      gnt      <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt    = GRANT;
          gnt_nxt      = pick_winner;
          beat_cnt_nxt = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          rr_ptr_nxt   = wrap_ptr;
          beat_cnt_nxt = '0;
          if (pick_valid) begin
            gnt_nxt = pick_winner;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
          end
        end else if (accept) begin
          beat_cnt_nxt = beat_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_en   = accept;
    busy   = (state == GRANT);
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) w_data = req_data[i*NUM_BITS +: NUM_BITS];
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic stall;
  assign stall = (state == GRANT) && owner_req && full;

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      beat_total <= '0;
      stall_cnt  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept && gnt[i] && (beat_total[i*STAT_W +: STAT_W] != {STAT_W{1'b1}})) begin
          beat_total[i*STAT_W +: STAT_W] <= beat_total[i*STAT_W +: STAT_W] + STAT_W'(1);
        end
      end
      if (stall && (stall_cnt != {STAT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: cycle model plus write-data scoreboard.
// Stats checks are compiled in when FIFO_ARB_STATS_EN is defined.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int NUM_BITS  = 8;
  localparam int MAX_BURST = 4;

  logic                        w_clk;
  logic                        w_rst;
  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*NUM_BITS-1:0] req_data;
  logic                        full;
  logic [NUM_REQ-1:0]          gnt;
  logic                        w_en;
  logic [NUM_BITS-1:0]         w_data;
  logic                        busy;
`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ*16-1:0]       beat_total;
  logic [15:0]                 stall_cnt;
`endif

  fifo_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .NUM_BITS  (NUM_BITS),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .w_clk      (w_clk),
    .w_rst      (w_rst),
    .req        (req),
    .req_data   (req_data),
    .full       (full),
    .gnt        (gnt),
    .w_en       (w_en),
    .w_data     (w_data),
    .busy       (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .beat_total (beat_total),
    .stall_cnt  (stall_cnt)
`endif
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  int vec_count   = 0;
  int miscompares = 0;
  int beats_seen  = 0;
  int m_owner     = -1;
  int m_cnt       = 0;
  int m_ptr       = 0;
  logic [NUM_BITS-1:0] sb_q[$];
  int grant_log[$];
  logic [NUM_REQ-1:0] prev_gnt = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic int rr_search(input logic [NUM_REQ-1:0] r, input int start,
                                   input int exclude);
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (start + k) % NUM_REQ;
      if (r[idx] && idx != exclude) return idx;
    end
    return -1;
  endfunction

  // One clock cycle: drive at the falling edge, check just after, then step the model.
  task automatic applyStimulus(input bit rst_v, input logic [NUM_REQ-1:0] req_v,
                               input bit full_v);
    logic [NUM_REQ-1:0] exp_gnt;
    bit m_acc;
    int gidx;
    @(negedge w_clk);
    w_rst    = rst_v;
    req      = req_v;
    full     = full_v;
    req_data = 32'($urandom);
    #1;
    exp_gnt = (m_owner >= 0) ? NUM_REQ'(1 << m_owner) : '0;
    m_acc   = (m_owner >= 0) && req_v[m_owner] && !full_v && !rst_v;
    if (m_acc) sb_q.push_back(req_data[m_owner*NUM_BITS +: NUM_BITS]);

    checkOutput("gnt", 32'(gnt), 32'(exp_gnt));
    checkOutput("w_en", 32'(w_en), 32'(m_acc));
    checkOutput("busy", 32'(busy), 32'(m_owner >= 0));
    if (m_owner < 0) checkOutput("w_data_idle", 32'(w_data), 32'd0);
    if (w_en) begin
      beats_seen++;
      checkOutput("sb_depth", 32'(sb_q.size()), 32'd1);
      if (sb_q.size() > 0) checkOutput("w_data", 32'(w_data), 32'(sb_q.pop_front()));
    end
    sb_q.delete();

    if (gnt != prev_gnt && gnt != '0) begin
      gidx = -1;
      for (int k = 0; k < NUM_REQ; k++) if (gnt[k]) gidx = k;
      grant_log.push_back(gidx);
    end
    prev_gnt = gnt;

    if (rst_v) begin
      m_owner = -1; m_cnt = 0; m_ptr = 0;
    end else if (m_owner < 0) begin
      m_owner = rr_search(req_v, m_ptr, -1);
      m_cnt   = 0;
    end else if (!req_v[m_owner] || (m_acc && m_cnt == MAX_BURST - 1)) begin
      m_ptr   = (m_owner + 1) % NUM_REQ;
      m_owner = rr_search(req_v, m_ptr, m_owner);
      m_cnt   = 0;
    end else if (m_acc) begin
      m_cnt++;
    end
  endtask

  initial begin
    w_rst = 1'b1; req = '0; full = 1'b0; req_data = '0;
    repeat (2) @(posedge w_clk);

    // Sole requester: four beats, one-cycle gap, then regranted.
    applyStimulus(1'b1, 4'b0000, 1'b0);
    beats_seen = 0;
    repeat (5) applyStimulus(1'b0, 4'b0001, 1'b0);
    checkOutput("s1_beats", 32'(beats_seen), 32'd4);
    applyStimulus(1'b0, 4'b0001, 1'b0);
    checkOutput("s1_gap_gnt", 32'(gnt), 32'h0);
    applyStimulus(1'b0, 4'b0001, 1'b0);
    checkOutput("s1_regrant", 32'(gnt), 32'h1);

    // All requesting: back-to-back bursts in order 0,1,2,3,0.
    applyStimulus(1'b1, 4'b0000, 1'b0);
    grant_log.delete();
    beats_seen = 0;
    repeat (21) applyStimulus(1'b0, 4'b1111, 1'b0);
    checkOutput("s2_beats", 32'(beats_seen), 32'd20);
    checkOutput("s2_grants", 32'(grant_log.size()), 32'd5);
    for (int k = 0; k < grant_log.size() && k < 5; k++)
      checkOutput("s2_order", 32'(grant_log[k]), 32'(k % NUM_REQ));

    // Owner 2 stalled by full after two beats, then finishes its burst.
    applyStimulus(1'b1, 4'b0000, 1'b0);
    beats_seen = 0;
    repeat (3) applyStimulus(1'b0, 4'b0100, 1'b0);
    checkOutput("s3_pre_beats", 32'(beats_seen), 32'd2);
    repeat (5) begin
      applyStimulus(1'b0, 4'b0100, 1'b1);
      checkOutput("s3_stall_wen", 32'(w_en), 32'd0);
      checkOutput("s3_stall_gnt", 32'(gnt), 32'h4);
      checkOutput("s3_stall_cnt", 32'(dut.beat_cnt), 32'd2);
    end
    beats_seen = 0;
    repeat (3) applyStimulus(1'b0, 4'b0100, 1'b0);
    checkOutput("s3_post_beats", 32'(beats_seen), 32'd2);
`ifdef FIFO_ARB_STATS_EN
    checkOutput("s3_stall_total", 32'(stall_cnt), 32'd5);
    checkOutput("s3_beat_total2", 32'(beat_total[2*16 +: 16]), 32'd4);
`endif

    // Owner 1 drops its request; pending requester 3 takes over directly.
    applyStimulus(1'b1, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b0010, 1'b0);
    applyStimulus(1'b0, 4'b1010, 1'b0);
    checkOutput("s4_beat", 32'(w_en), 32'd1);
    applyStimulus(1'b0, 4'b1000, 1'b0);
    checkOutput("s4_drop_gnt", 32'(gnt), 32'h2);
    applyStimulus(1'b0, 4'b1000, 1'b0);
    checkOutput("s4_handoff", 32'(gnt), 32'h8);
    checkOutput("s4_rr_ptr", 32'(dut.rr_ptr), 32'd2);

    // Reset mid-burst aborts it; the search restarts from pointer 0.
    applyStimulus(1'b1, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b0010, 1'b0);
    applyStimulus(1'b0, 4'b0010, 1'b0);
    applyStimulus(1'b1, 4'b0010, 1'b0);
    checkOutput("s5_rst_wen", 32'(w_en), 32'd0);
    applyStimulus(1'b0, 4'b1000, 1'b0);
    checkOutput("s5_gnt_clr", 32'(gnt), 32'h0);
    checkOutput("s5_busy_clr", 32'(busy), 32'd0);
    applyStimulus(1'b0, 4'b1000, 1'b0);
    checkOutput("s5_first_gnt", 32'(gnt), 32'h8);

    repeat (120) applyStimulus($urandom_range(0, 24) == 0, NUM_REQ'($urandom),
                               $urandom_range(0, 3) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
